// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl -- control FSM for the instruction-fetch stage.
//
// Sequences program preload into instruction memory, paced instruction
// fetch with a fixed memory read latency, the valid/ready handoff to ID,
// halting, and redirects requested by EX (target already on dataALU).
//
// Ports:
//   CLK, RST          clock (rising edge), asynchronous active-high reset
//   start             begin fetching from IDLE or HALT
//   load_req          request a program preload (IDLE only, beats start)
//   load_valid        one preload word present this cycle
//   load_last         qualifies the final load_valid beat
//   branch_taken      EX redirect request
//   halt_req          stop after the current instruction is handed off
//   id_ready          ID accepts the instruction this cycle
//   S_MXPC            PC mux select: 0 = PC+4, 1 = dataALU
//   W_PC              PC write enable (pulse)
//   read_file         instruction memory read enable
//   write_file, WE    instruction memory write strobes (preload)
//   if_valid          instruction valid towards ID
//   busy              high outside IDLE and HALT
//   fetch_count       instructions handed to ID (wraps)
//   flush_count       redirects taken (wraps)
module if_fetch_ctrl #(
   parameter int unsigned MEM_LAT = 1,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic             load_req,
   input  logic             load_valid,
   input  logic             load_last,
   input  logic             branch_taken,
   input  logic             halt_req,
   input  logic             id_ready,
   output logic             S_MXPC,
   output logic             W_PC,
   output logic             read_file,
   output logic             write_file,
   output logic             WE,
   output logic             if_valid,
   output logic             busy,
   output logic [CNT_W-1:0] fetch_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [2:0] {IDLE, LOAD, FETCH, WAIT, ISSUE, HALT} state_t;

   // FETCH loads MEM_LAT-1 so that WAIT spends MEM_LAT cycles before ISSUE.
   localparam logic [3:0] LAT_INIT = (MEM_LAT == 0) ? 4'd0 : 4'(MEM_LAT - 1);

   state_t     state, stateNext;
   logic [3:0] latCnt, latCntNext;
   logic       fetchInc, flushInc;
   logic       redirect;

   // Redirects only matter while an instruction is in flight.
   assign redirect = branch_taken && (state inside {FETCH, WAIT, ISSUE});

   always_comb begin
      stateNext  = state;
      latCntNext = latCnt;
      S_MXPC     = 1'b0;
      W_PC       = 1'b0;
      read_file  = 1'b0;
      write_file = 1'b0;
      WE         = 1'b0;
      if_valid   = 1'b0;
      busy       = 1'b1;
      fetchInc   = 1'b0;
      flushInc   = 1'b0;

      case (state)
         IDLE: begin
            busy = 1'b0;
            if (load_req)   stateNext = LOAD;
            else if (start) stateNext = FETCH;
         end
         LOAD: begin
            WE         = load_valid;
            write_file = load_valid;
            if (load_valid && load_last) stateNext = IDLE;
         end
         FETCH: begin
            read_file  = 1'b1;
            latCntNext = LAT_INIT;
            stateNext  = (MEM_LAT == 0) ? ISSUE : WAIT;
         end
         WAIT: begin
            read_file = 1'b1;
            if (latCnt == 4'd0) stateNext = ISSUE;
            else                latCntNext = latCnt - 4'd1;
         end
         ISSUE: begin
            read_file = 1'b1;
            if_valid  = 1'b1;
            if (id_ready) begin
               W_PC      = 1'b1;
               fetchInc  = 1'b1;
               stateNext = halt_req ? HALT : FETCH;
            end
         end
         HALT: begin
            // Resume at the held PC: no PC write on the way out.
            busy = 1'b0;
            if (start) stateNext = FETCH;
         end
         default: stateNext = IDLE;
      endcase

      // A redirect squashes whatever the state decoded above, including a
      // handshake or halt in the same cycle, and refetches from dataALU.
      if (redirect) begin
         W_PC       = 1'b1;
         S_MXPC     = 1'b1;
         if_valid   = 1'b0;
         fetchInc   = 1'b0;
         flushInc   = 1'b1;
         latCntNext = latCnt;
         stateNext  = FETCH;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= IDLE;
         latCnt      <= 4'd0;
         fetch_count <= '0;
         flush_count <= '0;
      end else begin
         state  <= stateNext;
         latCnt <= latCntNext;
         if (fetchInc) fetch_count <= fetch_count + CNT_W'(1);
         if (flushInc) flush_count <= flush_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl -- scenario bench for if_fetch_ctrl.
// Two instances share all inputs: dut (MEM_LAT = 1) and dutZ (MEM_LAT = 0).
// Each scenario queues per-cycle stimulus with hand-derived expected
// outputs and counter values; the expectation travels through a scoreboard
// queue and is compared when the outputs are sampled on the falling edge.
module tb_if_fetch_ctrl;
   localparam int CNT_W = 32;

   // input vector: {start, load_req, load_valid, load_last, branch_taken, halt_req, id_ready}
   localparam logic [6:0] ST = 7'b1000000, LR = 7'b0100000, LV = 7'b0010000,
                          LL = 7'b0001000, BT = 7'b0000100, HR = 7'b0000010,
                          IR = 7'b0000001, NO = 7'b0000000;
   // output vector: {S_MXPC, W_PC, read_file, write_file, WE, if_valid, busy}
   localparam logic [6:0] SM = 7'b1000000, WP = 7'b0100000, RF = 7'b0010000,
                          WF = 7'b0001000, WW = 7'b0000100, IV = 7'b0000010,
                          BZ = 7'b0000001, ZO = 7'b0000000;

   logic CLK = 1'b0;
   logic RST, start, load_req, load_valid, load_last, branch_taken, halt_req, id_ready;
   logic S_MXPC, W_PC, read_file, write_file, WE, if_valid, busy;
   logic [CNT_W-1:0] fetch_count, flush_count;
   logic zS_MXPC, zW_PC, zRead_file, zWrite_file, zWE, zIf_valid, zBusy;
   logic [CNT_W-1:0] zFetch_count, zFlush_count;
   logic [6:0] outs, zOuts;

   assign outs  = {S_MXPC, W_PC, read_file, write_file, WE, if_valid, busy};
   assign zOuts = {zS_MXPC, zW_PC, zRead_file, zWrite_file, zWE, zIf_valid, zBusy};

   always #5 CLK = ~CLK;

   if_fetch_ctrl #(.MEM_LAT(1), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST(RST), .start(start), .load_req(load_req),
      .load_valid(load_valid), .load_last(load_last), .branch_taken(branch_taken),
      .halt_req(halt_req), .id_ready(id_ready), .S_MXPC(S_MXPC), .W_PC(W_PC),
      .read_file(read_file), .write_file(write_file), .WE(WE), .if_valid(if_valid),
      .busy(busy), .fetch_count(fetch_count), .flush_count(flush_count));

   if_fetch_ctrl #(.MEM_LAT(0), .CNT_W(CNT_W)) dutZ (
      .CLK(CLK), .RST(RST), .start(start), .load_req(load_req),
      .load_valid(load_valid), .load_last(load_last), .branch_taken(branch_taken),
      .halt_req(halt_req), .id_ready(id_ready), .S_MXPC(zS_MXPC), .W_PC(zW_PC),
      .read_file(zRead_file), .write_file(zWrite_file), .WE(zWE), .if_valid(zIf_valid),
      .busy(zBusy), .fetch_count(zFetch_count), .flush_count(zFlush_count));

   typedef struct {
      logic [6:0]       in;
      logic [6:0]       out;
      logic [CNT_W-1:0] fc;
      logic [CNT_W-1:0] flc;
   } step_t;

   step_t stimQ[$];
   step_t expQ[$];
   logic [CNT_W-1:0] expFc, expFlc;
   int checks = 0;
   int errors = 0;

   // Queue one cycle: counters expected at that cycle are the values before
   // its own W_PC pulse takes effect.
   task automatic push(input logic [6:0] i, input logic [6:0] o);
      step_t s;
      s.in = i; s.out = o; s.fc = expFc; s.flc = expFlc;
      stimQ.push_back(s);
      if ((o & SM) != 0)      expFlc = expFlc + 1;
      else if ((o & WP) != 0) expFc  = expFc + 1;
   endtask

   task automatic drive(input logic [6:0] i);
      {start, load_req, load_valid, load_last, branch_taken, halt_req, id_ready} = i;
   endtask

   task automatic test_reset;
      RST = 1'b1;
      drive(NO);
      repeat (2) @(posedge CLK);
      #1;
      checks++;
      if (outs !== ZO || fetch_count !== 0 || flush_count !== 0) begin
         errors++;
         $display("FAIL reset_hold outs=%b fc=%0d flc=%0d want outs=0 fc=0 flc=0", outs, fetch_count, flush_count);
      end
      RST = 1'b0;
      @(negedge CLK);
      checks++;
      if (outs !== ZO || zOuts !== ZO) begin
         errors++;
         $display("FAIL reset_idle outs=%b zOuts=%b want 0000000", outs, zOuts);
      end
      @(posedge CLK); #1;
      expFc = '0; expFlc = '0;
   endtask

   task automatic test_fetch;
      step_t s, e;
      int cyc = 0;
      push(ST | IR, ZO);                       // IDLE
      for (int n = 0; n < 5; n++) begin
         logic [6:0] h;
         h = (n == 4) ? HR : NO;               // halt only on the last handoff
         push(IR | h, RF | BZ);                // FETCH
         push(IR | h, RF | BZ);                // WAIT
         push(IR | h, WP | RF | IV | BZ);      // ISSUE, handshake
      end
      push(IR, ZO);                            // HALT
      while (stimQ.size() != 0) begin
         s = stimQ.pop_front();
         drive(s.in);
         expQ.push_back(s);
         @(negedge CLK);
         e = expQ.pop_front();
         checks++;
         if (outs !== e.out || fetch_count !== e.fc || flush_count !== e.flc) begin
            errors++;
            $display("FAIL fetch cyc%0d outs=%b fc=%0d flc=%0d want outs=%b fc=%0d flc=%0d",
                     cyc, outs, fetch_count, flush_count, e.out, e.fc, e.flc);
         end
         cyc++;
         @(posedge CLK); #1;
      end
      checks++;
      if (fetch_count !== 5) begin
         errors++;
         $display("FAIL fetch_total fc=%0d want 5", fetch_count);
      end
   endtask

   task automatic test_backpressure;
      step_t s, e;
      int cyc = 0;
      int pulses = 0;
      push(ST, ZO);                            // HALT -> FETCH, no PC write
      push(NO, RF | BZ);                       // FETCH
      push(NO, RF | BZ);                       // WAIT
      repeat (4) push(NO, RF | IV | BZ);       // ISSUE stalled
      push(IR | HR, WP | RF | IV | BZ);        // handshake, halt
      push(BT | LR, ZO);                       // HALT ignores redirect/load
      push(NO, ZO);
      while (stimQ.size() != 0) begin
         s = stimQ.pop_front();
         drive(s.in);
         expQ.push_back(s);
         @(negedge CLK);
         e = expQ.pop_front();
         if (W_PC === 1'b1) pulses++;
         checks++;
         if (outs !== e.out || fetch_count !== e.fc || flush_count !== e.flc) begin
            errors++;
            $display("FAIL backpressure cyc%0d outs=%b fc=%0d flc=%0d want outs=%b fc=%0d flc=%0d",
                     cyc, outs, fetch_count, flush_count, e.out, e.fc, e.flc);
         end
         cyc++;
         @(posedge CLK); #1;
      end
      checks++;
      if (pulses !== 1 || fetch_count !== 6) begin
         errors++;
         $display("FAIL backpressure_total pulses=%0d fc=%0d want pulses=1 fc=6", pulses, fetch_count);
      end
   endtask

   task automatic test_redirect;
      step_t s, e;
      int cyc = 0;
      push(ST, ZO);                            // HALT
      push(NO, RF | BZ);                       // FETCH
      push(BT, SM | WP | RF | BZ);             // WAIT redirected
      push(NO, RF | BZ);                       // FETCH
      push(NO, RF | BZ);                       // WAIT
      push(BT | IR, SM | WP | RF | BZ);        // ISSUE squashed despite id_ready
      push(NO, RF | BZ);                       // FETCH
      push(NO, RF | BZ);                       // WAIT
      push(BT | HR | IR, SM | WP | RF | BZ);   // redirect beats halt
      push(BT, SM | WP | RF | BZ);             // FETCH, back-to-back redirect
      push(NO, RF | BZ);                       // FETCH
      push(NO, RF | BZ);                       // WAIT
      push(IR | HR, WP | RF | IV | BZ);        // handshake, halt
      push(NO, ZO);                            // HALT
      while (stimQ.size() != 0) begin
         s = stimQ.pop_front();
         drive(s.in);
         expQ.push_back(s);
         @(negedge CLK);
         e = expQ.pop_front();
         checks++;
         if (outs !== e.out || fetch_count !== e.fc || flush_count !== e.flc) begin
            errors++;
            $display("FAIL redirect cyc%0d outs=%b fc=%0d flc=%0d want outs=%b fc=%0d flc=%0d",
                     cyc, outs, fetch_count, flush_count, e.out, e.fc, e.flc);
         end
         cyc++;
         @(posedge CLK); #1;
      end
   endtask

   task automatic test_midwait_reset_preload;
      step_t s, e;
      int cyc = 0;
      int weCnt = 0;
      int wpCnt = 0;
      // Walk into WAIT, then hit RST between edges.
      drive(ST);
      @(posedge CLK); #1;
      drive(NO);
      @(posedge CLK); #1;
      @(negedge CLK);
      checks++;
      if (outs !== (RF | BZ) || fetch_count !== 7 || flush_count !== 4) begin
         errors++;
         $display("FAIL pre_reset_wait outs=%b fc=%0d flc=%0d want outs=%b fc=7 flc=4",
                  outs, fetch_count, flush_count, RF | BZ);
      end
      #2 RST = 1'b1;
      #1;
      checks++;
      if (outs !== ZO || fetch_count !== 0 || flush_count !== 0) begin
         errors++;
         $display("FAIL async_reset outs=%b fc=%0d flc=%0d want outs=0 fc=0 flc=0", outs, fetch_count, flush_count);
      end
      @(posedge CLK); #1;
      RST = 1'b0;
      expFc = '0; expFlc = '0;
      push(LR | ST, ZO);                       // IDLE: load beats start
      push(LV, WF | WW | BZ);
      push(BT | ST, BZ);                       // ignored in LOAD
      push(LV, WF | WW | BZ);
      push(LV, WF | WW | BZ);
      push(NO, BZ);
      push(LV | LL, WF | WW | BZ);             // 4th beat, last
      push(NO, ZO);                            // back in IDLE
      while (stimQ.size() != 0) begin
         s = stimQ.pop_front();
         drive(s.in);
         expQ.push_back(s);
         @(negedge CLK);
         e = expQ.pop_front();
         if (WE === 1'b1 && write_file === 1'b1) weCnt++;
         if (W_PC === 1'b1) wpCnt++;
         checks++;
         if (outs !== e.out || fetch_count !== e.fc || flush_count !== e.flc) begin
            errors++;
            $display("FAIL preload cyc%0d outs=%b fc=%0d flc=%0d want outs=%b fc=%0d flc=%0d",
                     cyc, outs, fetch_count, flush_count, e.out, e.fc, e.flc);
         end
         cyc++;
         @(posedge CLK); #1;
      end
      checks++;
      if (weCnt !== 4 || wpCnt !== 0) begin
         errors++;
         $display("FAIL preload_total we=%0d wpc=%0d want we=4 wpc=0", weCnt, wpCnt);
      end
   endtask

   // The MEM_LAT = 0 instance left reset and preload alongside the main one,
   // so it starts this scenario in IDLE with cleared counters.
   task automatic test_memlat0;
      step_t s, e;
      int cyc = 0;
      expFc = '0; expFlc = '0;
      push(ST | IR, ZO);                       // IDLE
      push(IR, RF | BZ);                       // FETCH
      push(IR, WP | RF | IV | BZ);             // ISSUE
      push(IR, RF | BZ);
      push(IR, WP | RF | IV | BZ);
      push(IR | HR, RF | BZ);
      push(IR | HR, WP | RF | IV | BZ);        // handshake, halt
      push(NO, ZO);                            // HALT
      while (stimQ.size() != 0) begin
         s = stimQ.pop_front();
         drive(s.in);
         expQ.push_back(s);
         @(negedge CLK);
         e = expQ.pop_front();
         checks++;
         if (zOuts !== e.out || zFetch_count !== e.fc || zFlush_count !== e.flc) begin
            errors++;
            $display("FAIL memlat0 cyc%0d outs=%b fc=%0d flc=%0d want outs=%b fc=%0d flc=%0d",
                     cyc, zOuts, zFetch_count, zFlush_count, e.out, e.fc, e.flc);
         end
         cyc++;
         @(posedge CLK); #1;
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_backpressure();
      test_redirect();
      test_midwait_reset_preload();
      test_memlat0();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
